// File: rtl/input_sync_debounce_pkg.sv
// Shared defaults and helpers for the input synchroniser / debouncer.
// Imported by the interface, the sync chain and the top module.
package input_sync_pkg;

   localparam int DEF_CHANNELS        = 4;
   localparam int DEF_SYNC_DEPTH      = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/input_sync_debounce_if.sv
// Board-input bundle: raw asynchronous inputs in, clean level and edge pulses out.
// The slave modport is the synchroniser side, the master modport the consumer side.
interface input_sync_debounce_if
   import input_sync_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS
);

   logic [CHANNELS-1:0] data_async_in;
   logic [CHANNELS-1:0] level_out;
   logic [CHANNELS-1:0] rise_out;
   logic [CHANNELS-1:0] fall_out;
   logic                changed_out;

   modport master (
      output data_async_in,
      input  level_out,
      input  rise_out,
      input  fall_out,
      input  changed_out
   );

   modport slave (
      input  data_async_in,
      output level_out,
      output rise_out,
      output fall_out,
      output changed_out
   );

endinterface

// File: rtl/input_sync_debounce_sync_chain.sv
// Single-channel flop-chain synchroniser; the chain resets to RESET_VAL so the
// channel starts from a known level that matches the debounced output.
module sync_chain
   import input_sync_pkg::*;
#(
   parameter int   DEPTH     = DEF_SYNC_DEPTH,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic data_in,
   output logic sync_out
);

   logic [DEPTH-1:0] stage;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stage <= {DEPTH{RESET_VAL}};
      end else begin
         stage <= {stage[DEPTH-2:0], data_in};
      end
   end

   assign sync_out = stage[DEPTH-1];

endmodule

// File: rtl/input_sync_debounce.sv
// Multi-channel synchroniser with optional per-channel debounce and edge pulses.
// Debounce counters exist only when INPUT_SYNC_DEBOUNCE_EN is defined.
module input_sync_debounce
   import input_sync_pkg::*;
#(
   parameter int                  CHANNELS        = DEF_CHANNELS,
   parameter int                  SYNC_DEPTH      = DEF_SYNC_DEPTH,
   parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [CHANNELS-1:0] RESET_LEVEL     = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input_sync_debounce_if.slave  io
);

   logic [CHANNELS-1:0] sync;
   logic [CHANNELS-1:0] lvl_d;
   logic [CHANNELS-1:0] lvl_q;
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] fall_q;
   logic                changed_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

      sync_chain #(
         .DEPTH     (SYNC_DEPTH),
         .RESET_VAL (RESET_LEVEL[i])
      ) u_sync (
         .clk_in   (clk_in),
         .rst_n_in (rst_n_in),
         .data_in  (io.data_async_in[i]),
         .sync_out (sync[i])
      );

`ifdef INPUT_SYNC_DEBOUNCE_EN
      if (DEBOUNCE_CYCLES > 1) begin : g_cnt
         localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
         localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

         // Down-counter of remaining stable cycles; terminal count at zero.
         logic [CNT_W-1:0] remain_q;
         logic             differ;
         logic             expired;

         assign differ   = sync[i] != lvl_q[i];
         assign expired  = differ && (remain_q == '0);
         assign lvl_d[i] = expired ? sync[i] : lvl_q[i];

         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               remain_q <= CNT_LOAD;
            end else if (!differ || expired) begin
               remain_q <= CNT_LOAD;
            end else begin
               remain_q <= remain_q - CNT_W'(1);
            end
         end
      end else begin : g_nocnt
         assign lvl_d[i] = sync[i];
      end
`else
      assign lvl_d[i] = sync[i];
`endif

   end

   // Pulses come from the same next-level value that updates lvl_q, so they
   // line up with the level flip; reset release itself never makes a pulse.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         lvl_q     <= RESET_LEVEL;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         lvl_q     <= lvl_d;
         rise_q    <= lvl_d & ~lvl_q;
         fall_q    <= ~lvl_d & lvl_q;
         changed_q <= |(lvl_d ^ lvl_q);
      end
   end

   assign io.level_out   = lvl_q;
   assign io.rise_out    = rise_q;
   assign io.fall_out    = fall_q;
   assign io.changed_out = changed_q;

endmodule

// File: tb/tb_input_sync_debounce.sv
// Directed bench for input_sync_debounce; expected level flips are queued when
// stimulus is applied and compared every cycle. Honours INPUT_SYNC_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_input_sync_debounce;
   import input_sync_pkg::*;

   localparam int CH  = 4;
   localparam int SD  = 2;
   localparam int DBC = 16;
`ifdef INPUT_SYNC_DEBOUNCE_EN
   localparam int DB  = DBC;
`else
   localparam int DB  = 1;
`endif
   localparam int         LAT   = SD + DB;
   localparam logic [3:0] RST_A = 4'b0000;
   localparam logic [3:0] RST_B = 4'b0101;

   typedef struct {
      int   edge_no;
      int   ch;
      logic rise;
   } ev_t;

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;
   always #5 clk_in = ~clk_in;

   input_sync_debounce_if #(.CHANNELS(CH)) bus_a ();
   input_sync_debounce_if #(.CHANNELS(CH)) bus_b ();

   input_sync_debounce #(
      .CHANNELS        (CH),
      .SYNC_DEPTH      (SD),
      .DEBOUNCE_CYCLES (DBC),
      .RESET_LEVEL     (RST_A)
   ) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .io       (bus_a)
   );

   input_sync_debounce #(
      .CHANNELS        (CH),
      .SYNC_DEPTH      (SD),
      .DEBOUNCE_CYCLES (DBC),
      .RESET_LEVEL     (RST_B)
   ) dut_b (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .io       (bus_b)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         edge_cnt = 0;
   ev_t        sb[$];
   ev_t        ev;
   logic [3:0] exp_level = RST_A;
   logic [3:0] pred      = RST_A;
   logic [3:0] er, ef;
   bit         mon_en    = 1'b1;

   always @(posedge clk_in) edge_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_cnt);
      end
   endtask

   // Per-cycle comparison against the queued level flips.
   always @(negedge clk_in) begin
      if (mon_en) begin
         er = '0;
         ef = '0;
         while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            ev = sb.pop_front();
            if (ev.edge_no != edge_cnt) check("event_edge", edge_cnt, ev.edge_no);
            if (ev.rise) er[ev.ch] = 1'b1;
            else         ef[ev.ch] = 1'b1;
            exp_level[ev.ch] = ev.rise;
         end
         check("level_a",   bus_a.level_out,   exp_level);
         check("rise_a",    bus_a.rise_out,    er);
         check("fall_a",    bus_a.fall_out,    ef);
         check("changed_a", bus_a.changed_out, |(er | ef));
         check("level_b",   bus_b.level_out,   RST_B);
         check("rise_b",    bus_b.rise_out,    0);
         check("fall_b",    bus_b.fall_out,    0);
         check("changed_b", bus_b.changed_out, 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Drive a pattern for 'hold' cycles; a channel is expected to flip only if
   // the new value differs from its settled level and lasts long enough.
   task automatic apply(input logic [3:0] val, input int hold);
      int e0;
      e0 = edge_cnt;
      bus_a.data_async_in = val;
      if (hold >= DB) begin
         for (int c = 0; c < CH; c++) begin
            if (val[c] != pred[c]) begin
               sb.push_back('{edge_no: e0 + LAT, ch: c, rise: val[c]});
               pred[c] = val[c];
            end
         end
      end
      tick(hold);
   endtask

   task automatic do_reset(input int cycles);
      rst_n_in  = 1'b0;
      sb.delete();
      pred      = RST_A;
      exp_level = RST_A;
      tick(cycles);
      rst_n_in  = 1'b1;
   endtask

   initial begin
      bus_a.data_async_in = 4'($urandom);
      bus_b.data_async_in = 4'($urandom);
      tick(1);
      // Reset held with random inputs on both instances.
      repeat (6) begin
         bus_a.data_async_in = 4'($urandom);
         bus_b.data_async_in = 4'($urandom);
         tick(1);
      end
      bus_a.data_async_in = RST_A;
      bus_b.data_async_in = RST_B;
      tick(2);
      rst_n_in = 1'b1;
      tick(40);

      // Clean step on ch0, then back down.
      apply(4'b0001, 40);
      apply(4'b0000, 40);

      // ch1: 15-cycle glitch, then exactly DBC cycles high, then low.
      apply(4'b0010, 15);
      apply(4'b0000, 30);
      apply(4'b0010, 16);
      apply(4'b0000, 30);

      // ch2: single-cycle glitch.
      apply(4'b0100, 1);
      apply(4'b0000, 25);

      // Simultaneous ch2 rise and ch3 fall.
      apply(4'b1000, 30);
      apply(4'b0100, 30);
      apply(4'b0000, 30);

      // All channels together.
      apply(4'b1111, 30);
      apply(4'b0000, 30);

      // Reset in the middle of a ch0 debounce, then a full interval after release.
      apply(4'b0001, SD + 10);
      do_reset(3);
      apply(4'b0001, 40);
      apply(4'b0000, 40);

      tick(5);
      check("sb_drained", sb.size(), 0);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, edge %0d", edge_cnt);
      $fatal(1, "watchdog expired");
   end

endmodule
